// File: rtl/matrix_line_scanner.sv
// Time-multiplexed LED matrix line scanner with a double-buffered line mask and blanking gaps.
// Optional brightness control via per-dwell duty threshold is enabled by MATRIX_LINE_BRIGHT_EN.
module matrix_line_scanner #(
   parameter int LINES     = 7,
   parameter int CODE_W    = 3,
   parameter int DWELL     = 1000,
   parameter int BLANK_CYC = 50
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_clear,
   output logic [LINES-1:0]  line_o,
   output logic              active_o,
   output logic              err_o
`ifdef MATRIX_LINE_BRIGHT_EN
   ,
   input  logic [3:0]        bright_i
`endif
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int BL_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [BL_W-1:0] BLANK_LAST = BL_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(LINES);

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   // Reset asserts immediately but releases two clocks later.
   logic [1:0] rst_sync_reg;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_reg <= 2'b00;
      else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_int_n = rst_sync_reg[1];

   state_t            state_reg, state_next;
   logic [LINES-1:0]  pending_reg, pending_next;
   logic [LINES-1:0]  shadow_reg;
   logic [CODE_W-1:0] cur_reg, cur_next;
   logic [DW_W-1:0]   dwell_reg, dwell_next;
   logic [BL_W-1:0]   blank_reg, blank_next;
   logic [LINES-1:0]  line_reg, line_next;
   logic              active_reg;
   logic              err_reg;
   logic [LINES-1:0]  hit;
   logic              write_ok;
   logic              load_shadow;
   logic [CODE_W-1:0] nxt_shadow, nxt_pend;

   assign write_ok = in_valid && (in_code <= CODE_MAX);

   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_hit
         assign hit[gi] = write_ok && ((in_code == '0) || (in_code == CODE_W'(gi + 1)));
      end
   endgenerate

   assign pending_next = (pending_reg & ~hit) | (hit & {LINES{~in_clear}});

   // First set bit strictly after 'from', wrapping; returns 'from' when it is the only one.
   function automatic logic [CODE_W-1:0] next_line(input logic [LINES-1:0] mask,
                                                    input logic [CODE_W-1:0] from);
      logic [CODE_W-1:0] res;
      logic              found;
      logic [LINES-1:0]  sh;
      int                idx;
      res   = from;
      found = 1'b0;
      for (int k = 1; k <= LINES; k++) begin
         idx = (int'(from) + k) % LINES;
         sh  = mask >> idx;
         if (!found && sh[0]) begin
            res   = CODE_W'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   assign nxt_shadow  = next_line(shadow_reg, cur_reg);
   assign nxt_pend    = next_line(pending_reg, cur_reg);
   assign load_shadow = (state_reg == IDLE) ||
                        ((state_reg == SHOW) && (dwell_reg == DWELL_LAST)) ||
                        ((state_reg == BLANK) && (blank_reg == BLANK_LAST));

   always_comb begin
      state_next = state_reg;
      cur_next   = cur_reg;
      dwell_next = dwell_reg;
      blank_next = blank_reg;
      case (state_reg)
         IDLE: begin
            if (shadow_reg != '0) begin
               state_next = SHOW;
               cur_next   = nxt_shadow;
               dwell_next = '0;
            end
         end
         SHOW: begin
            // End of dwell decides on the freshly copied mask, i.e. the pending one.
            if (dwell_reg == DWELL_LAST) begin
               if (pending_reg == '0) begin
                  state_next = IDLE;
               end else if ((nxt_pend == cur_reg) || (BLANK_CYC == 0)) begin
                  state_next = SHOW;
                  cur_next   = nxt_pend;
                  dwell_next = '0;
               end else begin
                  state_next = BLANK;
                  blank_next = '0;
               end
            end else begin
               dwell_next = dwell_reg + 1'b1;
            end
         end
         BLANK: begin
            if (blank_reg == BLANK_LAST) begin
               if (pending_reg == '0) begin
                  state_next = IDLE;
               end else begin
                  state_next = SHOW;
                  cur_next   = nxt_pend;
                  dwell_next = '0;
               end
            end else begin
               blank_next = blank_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef MATRIX_LINE_BRIGHT_EN
   localparam int TH_W = $clog2(DWELL + 1);
   logic [TH_W-1:0] thr_reg, thr_next;
   logic            show_entry;

   assign show_entry = (state_next == SHOW) &&
                       ((state_reg != SHOW) || (dwell_reg == DWELL_LAST));
   assign thr_next   = show_entry ? TH_W'(((int'(bright_i) + 1) * DWELL) >> 4) : thr_reg;

   always_comb begin
      line_next = '0;
      if ((state_next == SHOW) && (int'(dwell_next) < int'(thr_next)))
         line_next = LINES'(1) << cur_next;
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) thr_reg <= '0;
      else            thr_reg <= thr_next;
   end
`else
   always_comb begin
      line_next = '0;
      if (state_next == SHOW)
         line_next = LINES'(1) << cur_next;
   end
`endif

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_reg   <= IDLE;
         pending_reg <= '0;
         shadow_reg  <= '0;
         cur_reg     <= CODE_W'(LINES - 1);
         dwell_reg   <= '0;
         blank_reg   <= '0;
         line_reg    <= '0;
         active_reg  <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         cur_reg     <= cur_next;
         dwell_reg   <= dwell_next;
         blank_reg   <= blank_next;
         line_reg    <= line_next;
         err_reg     <= in_valid && (in_code > CODE_MAX);
         if (load_shadow) begin
            shadow_reg <= pending_reg;
            active_reg <= |pending_reg;
         end
      end
   end

   assign line_o   = line_reg;
   assign active_o = active_reg;
   assign err_o    = err_reg;

endmodule

// File: tb/tb_matrix_line_scanner.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_matrix_line_scanner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, v6 = 1'b0;
   logic [2:0] in_code = '0, code6 = '0;
   logic       in_clear = 1'b0, clr6 = 1'b0;
   logic [6:0] line_o;
   logic [5:0] line6;
   logic       active_o, err_o, active6, err6;
   logic [3:0] bright = 4'd15;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   logic [6:0] snap_line = '0;
   logic       snap_active = 1'b0;
   logic       done = 1'b0;

   typedef struct {
      int         cyc;
      int         kind;
      logic [6:0] val;
      string      name;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matrix_line_scanner #(.LINES(7), .CODE_W(3), .DWELL(4), .BLANK_CYC(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code), .in_clear(in_clear),
      .line_o(line_o), .active_o(active_o), .err_o(err_o)
`ifdef MATRIX_LINE_BRIGHT_EN
      , .bright_i(bright)
`endif
   );

   matrix_line_scanner #(.LINES(6), .CODE_W(3), .DWELL(4), .BLANK_CYC(2)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_code(code6), .in_clear(clr6),
      .line_o(line6), .active_o(active6), .err_o(err6)
`ifdef MATRIX_LINE_BRIGHT_EN
      , .bright_i(4'd15)
`endif
   );

   function automatic logic [6:0] sample(input int kind);
      case (kind)
         0:       return line_o;
         1:       return {6'b0, active_o};
         2:       return {6'b0, err_o};
         3:       return {6'b0, err6};
         4:       return {6'b0, active6};
         5:       return {1'b0, line6};
         6:       return snap_line;
         default: return {6'b0, snap_active};
      endcase
   endfunction

   task automatic expect_rng(input int c0, input int c1, input int kind,
                             input logic [6:0] val, input string name);
      for (int c = c0; c <= c1; c++) q.push_back('{c, kind, val, name});
   endtask

   task automatic wr_at(input int e, input bit six, input logic [2:0] code, input logic clr);
      if (cyc >= e) begin
         $display("FAIL schedule: write for edge %0d issued late at cycle %0d", e, cyc);
         $fatal(1, "schedule overrun");
      end
      while (cyc != e - 1) @(negedge clk);
      if (six) begin v6 = 1'b1; code6 = code; clr6 = clr; end
      else begin in_valid = 1'b1; in_code = code; in_clear = clr; end
      $display("write dut=%s edge=%0d code=%0d clear=%0b", six ? "L6" : "L7", e, code, clr);
      @(negedge clk);
      v6 = 1'b0;
      in_valid = 1'b0;
   endtask

   // Monitor: the only process that touches the counters.
   always @(negedge clk) begin
      n_checks++;
      if (!$onehot0(line_o)) begin
         n_fail++;
         $display("FAIL onehot cyc=%0d got=%b want=at most one bit", cyc, line_o);
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc == cyc) begin
            n_checks++;
            if (sample(q[i].kind) !== q[i].val) begin
               n_fail++;
               $display("FAIL %s cyc=%0d got=%b want=%b", q[i].name, cyc,
                        sample(q[i].kind), q[i].val);
            end
            q.delete(i);
         end else if (q[i].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s cyc=%0d got=unsampled want=%b", q[i].name, q[i].cyc, q[i].val);
            q.delete(i);
         end
      end
      if (done) begin
         n_checks++;
         if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d want=0 outstanding", q.size());
         end
         done <= 1'b0;
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state while rst_n is held low.
      expect_rng(2, 3, 0, 7'd0, "rst_line");
      expect_rng(2, 3, 1, 7'd0, "rst_active");
      expect_rng(2, 3, 2, 7'd0, "rst_err");
      expect_rng(2, 3, 5, 7'd0, "rst_line6");
      while (cyc != 4) @(negedge clk);
      rst_n = 1'b1;

      // Single line: shown from E0+2 without gaps; then clear-all mid-dwell at 21.
      expect_rng(10, 11, 0, 7'd0, "first_latency");
      expect_rng(12, 23, 0, 7'b0000100, "single_line");
      expect_rng(10, 10, 1, 7'd0, "active_pre");
      expect_rng(11, 23, 1, 7'd1, "active_on");
      expect_rng(11, 11, 2, 7'd0, "err_valid_code");
      expect_rng(24, 31, 0, 7'd0, "clear_all_idle");
      expect_rng(24, 30, 1, 7'd0, "clear_all_active");
      wr_at(10, 0, 3'd3, 1'b0);
      wr_at(21, 0, 3'd0, 1'b1);

      // Scan order 0,4,6 with two-cycle blanks.
      expect_rng(31, 81, 1, 7'd1, "scan_active");
      expect_rng(32, 35, 0, 7'b0000001, "scan_l0");
      expect_rng(36, 37, 0, 7'd0, "scan_blank");
      expect_rng(38, 41, 0, 7'b0010000, "scan_l4");
      expect_rng(42, 43, 0, 7'd0, "scan_blank");
      expect_rng(44, 47, 0, 7'b1000000, "scan_l6");
      expect_rng(48, 49, 0, 7'd0, "scan_blank");
      expect_rng(50, 53, 0, 7'b0000001, "scan_l0_again");
      expect_rng(54, 55, 0, 7'd0, "scan_blank");
      expect_rng(56, 59, 0, 7'b0010000, "tearfree_l4");
      expect_rng(40, 40, 2, 7'd0, "err_main_quiet");

      // Error on the six-line instance; pending must not change.
      expect_rng(39, 39, 3, 7'd0, "err6_pre");
      expect_rng(40, 40, 3, 7'd1, "err6_pulse");
      expect_rng(41, 41, 3, 7'd0, "err6_end");
      expect_rng(41, 45, 4, 7'd0, "err6_pending_idle");
      expect_rng(41, 45, 5, 7'd0, "err6_line_idle");
      expect_rng(50, 51, 3, 7'd0, "err6_valid");
      expect_rng(51, 70, 4, 7'd1, "line6_active");
      expect_rng(50, 51, 5, 7'd0, "line6_latency");
      expect_rng(52, 70, 5, 7'b0100000, "line6_hold");
      expect_rng(60, 60, 3, 7'd1, "err6_pulse2");
      expect_rng(61, 61, 3, 7'd0, "err6_end2");

      wr_at(30, 0, 3'd1, 1'b0);
      wr_at(31, 0, 3'd5, 1'b0);
      wr_at(32, 0, 3'd7, 1'b0);
      wr_at(40, 1, 3'd7, 1'b0);
      wr_at(50, 1, 3'd6, 1'b0);

      // Clearing line 4 during its dwell: it finishes, then drops out of the rotation.
      expect_rng(60, 61, 0, 7'd0, "tearfree_blank");
      expect_rng(62, 65, 0, 7'b1000000, "tearfree_l6");
      expect_rng(66, 67, 0, 7'd0, "tearfree_blank");
      expect_rng(68, 71, 0, 7'b0000001, "tearfree_l0");
      expect_rng(72, 73, 0, 7'd0, "tearfree_blank");
      expect_rng(74, 77, 0, 7'b1000000, "tearfree_l6b");
      expect_rng(78, 79, 0, 7'd0, "tearfree_blank");
      expect_rng(80, 81, 0, 7'b0000001, "tearfree_l0b");
      wr_at(57, 0, 3'd5, 1'b1);
      wr_at(60, 1, 3'd7, 1'b1);

      // Asynchronous reset mid-dwell, captured before the next clock edge.
      while (cyc != 81) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      snap_line   = line_o;
      snap_active = active_o;
      expect_rng(82, 82, 6, 7'd0, "async_rst_line");
      expect_rng(82, 82, 7, 7'd0, "async_rst_active");
      expect_rng(83, 91, 0, 7'd0, "rst_hold_line");
      expect_rng(83, 91, 1, 7'd0, "rst_hold_active");
      expect_rng(83, 91, 5, 7'd0, "rst_hold_line6");
      while (cyc != 86) @(negedge clk);
      rst_n = 1'b1;

`ifdef MATRIX_LINE_BRIGHT_EN
      // Brightness 3 with DWELL=4: threshold (4*4)>>4 = 1 cycle lit per dwell.
      bright = 4'd3;
      expect_rng(92, 93, 0, 7'd0, "bright_latency");
      expect_rng(94, 94, 0, 7'b0000001, "bright_on");
      expect_rng(95, 97, 0, 7'd0, "bright_off");
      expect_rng(98, 98, 0, 7'b0000001, "bright_on2");
      expect_rng(99, 101, 0, 7'd0, "bright_off2");
      expect_rng(93, 101, 1, 7'd1, "bright_active");
      wr_at(92, 0, 3'd1, 1'b0);
`endif

      while (cyc < 104) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_line_scanner.md
Name: matrix_line_scanner

Overview:
Parametrised, time-multiplexed line driver for the LED matrix. It generalises the 3-bit code to one-hot line decoder into a sequential scanner. Host writes set or clear individual lines in a pending mask, and the block double-buffers that mask. The block then cycles through every lit line, holding each for a dwell period and inserting a blanking gap between different lines to prevent ghosting. It sits between the character/control logic and the matrix line pins.

Parameters:
LINES, 7, number of matrix lines (1..15)
CODE_W, 3, width of line code; must satisfy 2**CODE_W > LINES
DWELL, 1000, clock cycles each selected line is shown (>=1)
BLANK_CYC, 50, all-lines-off cycles inserted between two different lines (0 = no gap)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  write strobe, one write per high cycle
in_code  input  CODE_W  line code: 1..LINES selects line index code-1; 0 = all lines
in_clear  input  1  0 = set line(s), 1 = clear line(s)
line_o  output  LINES  one-hot (or zero) line drive, registered
active_o  output  1  high while the displayed (shadow) mask is non-zero, registered
err_o  output  1  one-cycle pulse on a write with in_code > LINES

Behaviour:
- Reset (async, rst_n=0): pending=0, shadow=0, state=IDLE, cur=LINES-1, dwell/blank counters=0, line_o=0, active_o=0, err_o=0. Deassertion is synchronised by a 2-flop release.
- Write on in_valid edge E0, code 1..LINES: pending[code-1] is set or cleared per in_clear.
- Code 0 with in_clear=1 clears all pending bits. Code 0 with in_clear=0 sets all pending bits.
- Code > LINES: pending is unchanged and err_o=1 in the following cycle.
- Shadow mask: copied from pending every cycle in IDLE, and on the last cycle of SHOW or BLANK. This gives tear-free updates: a change never alters the current dwell.
- Next-line search: rotating priority, first set bit of shadow strictly after cur, wrapping LINES-1 -> 0. If cur is the only set bit, next = cur.
- FSM states: IDLE, SHOW, BLANK.
- IDLE:
  - line_o=0.
  - If shadow != 0: go to SHOW with cur=next and dwell counter cleared.
  - Latency: write at E0, shadow at E1, line_o one-hot valid after E2.
- SHOW:
  - line_o = onehot(cur) for exactly DWELL cycles.
  - On the last cycle, evaluate the new shadow (from pending):
    - zero: go to IDLE; line_o=0 from the next cycle.
    - next == cur: restart SHOW with no gap; line_o stays continuously high.
    - otherwise: go to BLANK (or straight to SHOW(next) if BLANK_CYC=0).
- BLANK:
  - line_o=0 for BLANK_CYC cycles, then SHOW(next).
  - next is re-evaluated on the last BLANK cycle. If the shadow is zero by then, go to IDLE.
- Clearing the currently shown line does not truncate its dwell.
- active_o = |shadow, registered, updated with the shadow copy.
- line_o is never multi-hot in any state.
- Counters are sized by $clog2 of DWELL and BLANK_CYC. No wrap occurs, since each counter reloads at terminal count.
- A reset asserted mid-SHOW zeroes line_o immediately (asynchronously).

Optional Feature:
Macro: MATRIX_LINE_BRIGHT_EN.
- Defined:
  - Adds port bright_i input 4 (brightness level).
  - On SHOW entry, latch thr = ((bright_i+1)*DWELL)>>4.
  - Within SHOW, line_o = onehot(cur) only while dwell counter < thr; otherwise 0. thr=0 means dark.
  - Dwell length, FSM timing and active_o are unchanged.
- Undefined: bright_i is absent and line_o is high for the full dwell.

Test Plan:
1. Reset and first write. LINES=7, DWELL=4, BLANK_CYC=2. Release reset, then write code=3, in_clear=0 at E0 -> line_o=7'b0000100 from E2, held continuously (single line, no blank gap); active_o=1.
2. Scan order. Write codes 1, 5, 7 -> repeating sequence: line 0 x4, 0 x2, line 4 x4, 0 x2, line 6 x4, 0 x2, line 0; never multi-hot.
3. Tear-free clear. During line 4's dwell, write code=5 in_clear=1 -> line 4 completes all 4 cycles; line 4 is absent from later rounds.
4. Clear all. Write code=0 in_clear=1 mid-SHOW -> current dwell finishes, then IDLE; line_o=0 and active_o=0 one cycle later.
5. Error. Write code=7 with LINES=6 -> err_o pulses 1 cycle; pending is unchanged.
6. Async reset and brightness. Drive rst_n=0 mid-SHOW -> line_o=0 with no clock edge. With MATRIX_LINE_BRIGHT_EN, DWELL=16, bright_i=3 -> line high for 4 of 16 cycles.
